// File: rtl/pattern_broadcaster.sv
// -----------------------------------------------------------------------------
// pattern_broadcaster
//
// Turns a handful of chip-level pins into full-width adder operands for the
// N-bit adder DFT example. Each accepted request produces one new operand set
// with a single-cycle valid strobe.
//
//   mode 00 : broadcast  - replicate pin_a / pin_b across all bits
//   mode 01 : shift      - load operands serially, LSB first, over N cycles
//   mode 10 : count      - operands from an internal pattern counter
//                          (only when PATTERN_BROADCASTER_COUNT_EN is defined,
//                          otherwise treated as broadcast)
//   mode 11 : reserved   - treated as broadcast
//
// Optional feature macro: PATTERN_BROADCASTER_COUNT_EN
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   pin_a    in   1  operand-a pin (broadcast value or serial bit)
//   pin_b    in   1  operand-b pin (broadcast value or serial bit)
//   pin_cin  in   1  carry-in pin
//   mode     in   2  request mode, sampled only when a request is accepted
//   start    in   1  request strobe (ignored while a shift is in progress)
//   a        out  N  operand a (registered)
//   b        out  N  operand b (registered)
//   cin      out  1  carry-in (registered)
//   valid    out  1  one-cycle pulse, a/b/cin updated this cycle
//   busy     out  1  high while a shift request is in progress
// -----------------------------------------------------------------------------
module pattern_broadcaster #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pin_a,
   input  logic         pin_b,
   input  logic         pin_cin,
   input  logic [1:0]   mode,
   input  logic         start,
   output logic [N-1:0] a,
   output logic [N-1:0] b,
   output logic         cin,
   output logic         valid,
   output logic         busy
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   typedef enum logic [1:0] {
      MODE_BCAST = 2'b00,
      MODE_SHIFT = 2'b01,
      MODE_COUNT = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_t;

   state_t        r_state,   w_state_nx;
   logic [CW-1:0] r_bit_cnt, w_bit_cnt_nx;
   logic [N-1:0]  r_sh_a,    w_sh_a_nx;
   logic [N-1:0]  r_sh_b,    w_sh_b_nx;
   logic [N-1:0]  r_a,       w_a_nx;
   logic [N-1:0]  r_b,       w_b_nx;
   logic          r_cin,     w_cin_nx;
   logic          r_valid,   w_valid_nx;
`ifdef PATTERN_BROADCASTER_COUNT_EN
   logic [N-1:0]  r_cnt,     w_cnt_nx;
`endif

   // Next-state / next-output logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; that is what keeps this block free of inferred latches.
      w_state_nx   = r_state;
      w_bit_cnt_nx = r_bit_cnt;
      w_sh_a_nx    = r_sh_a;
      w_sh_b_nx    = r_sh_b;
      w_a_nx       = r_a;
      w_b_nx       = r_b;
      w_cin_nx     = r_cin;
      w_valid_nx   = 1'b0;
`ifdef PATTERN_BROADCASTER_COUNT_EN
      w_cnt_nx     = r_cnt;
`endif

      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (mode_t'(mode))
                  MODE_SHIFT: begin
                     w_state_nx   = S_SHIFT;
                     w_bit_cnt_nx = '0;
                  end
`ifdef PATTERN_BROADCASTER_COUNT_EN
                  MODE_COUNT: begin
                     w_a_nx     = r_cnt;
                     w_b_nx     = ~r_cnt;
                     w_cin_nx   = r_cnt[0];
                     w_valid_nx = 1'b1;
                     w_cnt_nx   = r_cnt + N'(1);   // wraps naturally at 2^N
                  end
`endif
                  // Broadcast, plus every mode without a dedicated handler.
                  default: begin
                     w_a_nx     = {N{pin_a}};
                     w_b_nx     = {N{pin_b}};
                     w_cin_nx   = pin_cin;
                     w_valid_nx = 1'b1;
                  end
               endcase
            end
         end

         S_SHIFT: begin
            if (r_bit_cnt == LAST_BIT) begin
               // Final bit goes straight to the outputs so a/b/cin change
               // atomically on the completing edge.
               w_a_nx     = {pin_a, r_sh_a[N-1:1]};
               w_b_nx     = {pin_b, r_sh_b[N-1:1]};
               w_cin_nx   = pin_cin;
               w_valid_nx = 1'b1;
               w_state_nx = S_IDLE;
            end else begin
               // Shift in from the MSB: the first sample ends up in bit 0.
               w_sh_a_nx    = {pin_a, r_sh_a[N-1:1]};
               w_sh_b_nx    = {pin_b, r_sh_b[N-1:1]};
               w_bit_cnt_nx = r_bit_cnt + CW'(1);
            end
         end

         default: w_state_nx = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_sh_a    <= '0;
         r_sh_b    <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_cin     <= 1'b0;
         r_valid   <= 1'b0;
`ifdef PATTERN_BROADCASTER_COUNT_EN
         r_cnt     <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values, independent of statement order.
         r_state   <= w_state_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_sh_a    <= w_sh_a_nx;
         r_sh_b    <= w_sh_b_nx;
         r_a       <= w_a_nx;
         r_b       <= w_b_nx;
         r_cin     <= w_cin_nx;
         r_valid   <= w_valid_nx;
`ifdef PATTERN_BROADCASTER_COUNT_EN
         r_cnt     <= w_cnt_nx;
`endif
      end
   end

   assign a     = r_a;
   assign b     = r_b;
   assign cin   = r_cin;
   assign valid = r_valid;
   assign busy  = (r_state == S_SHIFT);

endmodule

// File: tb/tb_pattern_broadcaster.sv
// -----------------------------------------------------------------------------
// tb_pattern_broadcaster
//
// Directed, self-checking bench for pattern_broadcaster. A 16-bit instance
// covers reset, broadcast, shift and robustness; a 4-bit instance sharing the
// same inputs covers count mode (or the broadcast fallback of mode 10 when
// PATTERN_BROADCASTER_COUNT_EN is not defined).
// -----------------------------------------------------------------------------
module tb_pattern_broadcaster;

   localparam int N  = 16;
   localparam int N4 = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pin_a, pin_b, pin_cin, start;
   logic [1:0]    mode;
   logic [N-1:0]  a, b;
   logic          cin, valid, busy;
   logic [N4-1:0] a4, b4;
   logic          cin4, valid4, busy4;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [N-1:0] exp_a, exp_b;
   logic         exp_cin;

   pattern_broadcaster #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .pin_a(pin_a), .pin_b(pin_b),
      .pin_cin(pin_cin), .mode(mode), .start(start),
      .a(a), .b(b), .cin(cin), .valid(valid), .busy(busy)
   );

   pattern_broadcaster #(.N(N4)) dut4 (
      .clk(clk), .rst_n(rst_n), .pin_a(pin_a), .pin_b(pin_b),
      .pin_cin(pin_cin), .mode(mode), .start(start),
      .a(a4), .b(b4), .cin(cin4), .valid(valid4), .busy(busy4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs,
                        input logic [N-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Full serial load; optionally pulse start (mode 00) at one bit position,
   // which must be ignored.
   task automatic run_shift(input logic [N-1:0] va, input logic [N-1:0] vb,
                            input logic vcin, input int glitch_at);
      mode  = 2'b01;
      start = 1'b1;
      tick();
      check("shift_accept_busy", N'(busy), N'(1));
      check("shift_accept_valid", N'(valid), N'(0));
      start = 1'b0;
      mode  = 2'b00;
      for (int i = 0; i < N; i++) begin
         pin_a   = va[i];
         pin_b   = vb[i];
         // Wrong cin on all but the last bit catches sampling on the wrong edge.
         pin_cin = (i == N - 1) ? vcin : ~vcin;
         start   = (i == glitch_at);
         tick();
         start = 1'b0;
         if (i < N - 1) begin
            check("shift_mid_busy", N'(busy), N'(1));
            check("shift_mid_valid", N'(valid), N'(0));
            check("shift_mid_a_hold", a, exp_a);
            check("shift_mid_b_hold", b, exp_b);
            check("shift_mid_cin_hold", N'(cin), N'(exp_cin));
         end else begin
            check("shift_done_a", a, va);
            check("shift_done_b", b, vb);
            check("shift_done_cin", N'(cin), N'(vcin));
            check("shift_done_valid", N'(valid), N'(1));
            check("shift_done_busy", N'(busy), N'(0));
         end
      end
      exp_a   = va;
      exp_b   = vb;
      exp_cin = vcin;
      tick();
      check("shift_after_valid", N'(valid), N'(0));
      check("shift_after_busy", N'(busy), N'(0));
   endtask

   initial begin
      logic [N-1:0]  abort_pat;
      logic [N4-1:0] e4;

      // Reset.
      rst_n = 1'b0; start = 1'b0; mode = 2'b00;
      pin_a = 1'b1; pin_b = 1'b1; pin_cin = 1'b1;
      #2;
      check("rst_a", a, '0);
      check("rst_b", b, '0);
      check("rst_cin", N'(cin), N'(0));
      check("rst_valid", N'(valid), N'(0));
      check("rst_busy", N'(busy), N'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_a", a, '0);
      check("idle_b", b, '0);
      check("idle_cin", N'(cin), N'(0));
      check("idle_valid", N'(valid), N'(0));
      check("idle_busy", N'(busy), N'(0));

      // Broadcast 0/1/0.
      pin_a = 1'b0; pin_b = 1'b1; pin_cin = 1'b0; mode = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      check("bc1_a", a, 16'h0000);
      check("bc1_b", b, 16'hFFFF);
      check("bc1_cin", N'(cin), N'(0));
      check("bc1_valid", N'(valid), N'(1));
      check("bc1_busy", N'(busy), N'(0));
      tick();
      check("bc1_valid_drop", N'(valid), N'(0));
      check("bc1_b_hold", b, 16'hFFFF);

      // Broadcast 1/0/1.
      pin_a = 1'b1; pin_b = 1'b0; pin_cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("bc2_a", a, 16'hFFFF);
      check("bc2_b", b, 16'h0000);
      check("bc2_cin", N'(cin), N'(1));
      check("bc2_valid", N'(valid), N'(1));
      tick();
      check("bc2_valid_drop", N'(valid), N'(0));

      // Back-to-back: reserved mode 11 behaves as broadcast, then mode 00.
      pin_a = 1'b0; pin_b = 1'b1; pin_cin = 1'b0; mode = 2'b11; start = 1'b1;
      tick();
      check("b2b1_a", a, 16'h0000);
      check("b2b1_b", b, 16'hFFFF);
      check("b2b1_valid", N'(valid), N'(1));
      pin_a = 1'b1; pin_b = 1'b0; pin_cin = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0;
      check("b2b2_a", a, 16'hFFFF);
      check("b2b2_b", b, 16'h0000);
      check("b2b2_cin", N'(cin), N'(1));
      check("b2b2_valid", N'(valid), N'(1));
      tick();
      check("b2b_valid_drop", N'(valid), N'(0));
      exp_a = 16'hFFFF; exp_b = 16'h0000; exp_cin = 1'b1;

      // Shift A5C3 / 3C5A, then the same again with an ignored start pulse.
      run_shift(16'hA5C3, 16'h3C5A, 1'b1, -1);
      run_shift(16'h5A3C, 16'hC3A5, 1'b0, 5);
      run_shift(16'hA5C3, 16'h3C5A, 1'b1, 9);

      // Reset after bit 8 of a shift: outputs clear, no valid.
      abort_pat = 16'hFFFF;
      mode = 2'b01; start = 1'b1;
      tick();
      start = 1'b0; mode = 2'b00;
      for (int i = 0; i < 8; i++) begin
         pin_a = abort_pat[i]; pin_b = abort_pat[i]; pin_cin = 1'b1;
         tick();
      end
      check("abort_busy_before", N'(busy), N'(1));
      rst_n = 1'b0;
      #1;
      check("abort_a", a, '0);
      check("abort_b", b, '0);
      check("abort_cin", N'(cin), N'(0));
      check("abort_valid", N'(valid), N'(0));
      check("abort_busy", N'(busy), N'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("abort_no_valid", N'(valid), N'(0));
         check("abort_no_busy", N'(busy), N'(0));
      end
      exp_a = '0; exp_b = '0; exp_cin = 1'b0;
      run_shift(16'h1234, 16'hEDCB, 1'b0, -1);

      // Count mode on the 4-bit instance.
      tick();
      pin_a = 1'b1; pin_b = 1'b0; pin_cin = 1'b1; mode = 2'b10; start = 1'b1;
`ifdef PATTERN_BROADCASTER_COUNT_EN
      for (int r = 0; r < 18; r++) begin
         tick();
         e4 = N4'(r);
         if (r < 3 || r >= 16) begin
            check("cnt_a", N'(a4), N'(e4));
            check("cnt_b", N'(b4), N'(~e4));
            check("cnt_cin", N'(cin4), N'(e4[0]));
            check("cnt_valid", N'(valid4), N'(1));
         end
      end
`else
      tick();
      e4 = 4'hF;
      check("m10_bc_a4", N'(a4), N'(e4));
      check("m10_bc_b4", N'(b4), N'(0));
      check("m10_bc_cin4", N'(cin4), N'(1));
      check("m10_bc_valid4", N'(valid4), N'(1));
      check("m10_bc_a", a, 16'hFFFF);
      check("m10_bc_b", b, 16'h0000);
`endif
      start = 1'b0;
      tick();
      check("cnt_valid_drop", N'(valid4), N'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_broadcaster.md
# pattern_broadcaster

Sequential, parametrised operand source for the N-bit adder DFT example. It turns a few chip-level pins into full-width adder operands `a`, `b` and carry-in `cin`. Supported modes:
- **Broadcast:** replicate each pin across all bits.
- **Shift:** load the operands serially, LSB first, from the pins.
- **Count (optional):** generate operands from an internal counter.

The block sits between the pad ring and the adder under test and presents each new operand set with a one-cycle `valid` strobe.

## Interface
- `N`, default 16: operand width in bits; legal range N ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pin_a`  in  1  operand-a pin (broadcast value or serial bit).
- `pin_b`  in  1  operand-b pin (broadcast value or serial bit).
- `pin_cin`  in  1  carry-in pin.
- `mode`  in  2  request mode:
  - 00 broadcast.
  - 01 shift.
  - 10 count (only when the count feature is compiled in).
  - 11 reserved.
- `start`  in  1  request strobe, sampled on the rising edge of `clk`.
- `a`  out  N  operand a (registered).
- `b`  out  N  operand b (registered).
- `cin`  out  1  carry-in (registered).
- `valid`  out  1  one-cycle pulse; `a`/`b`/`cin` updated this cycle.
- `busy`  out  1  high while a shift request is in progress.
- Reset values: `a`=0, `b`=0, `cin`=0, `valid`=0, `busy`=0. Internal: state IDLE, bit counter 0, shadow registers 0, pattern counter 0.
- Reset is asynchronous and active-low; one clock domain.

## Operation
- States: IDLE, SHIFT.
- IDLE, `start`=1, `mode`=00 (broadcast):
  - `a` ← {N{pin_a}}, `b` ← {N{pin_b}}, `cin` ← pin_cin.
  - `valid`=1 for one cycle; state stays IDLE.
- IDLE, `start`=1, `mode`=01 (shift):
  - Enter SHIFT with bit counter = 0 and `busy`=1.
  - Each SHIFT cycle samples `pin_a`/`pin_b` into shadow registers, shifting in from the MSB, so the first bit sampled ends up in bit 0.
  - On the Nth sample:
    - `a` ← {pin_a, shadow_a[N-1:1]}, `b` likewise.
    - `cin` ← pin_cin sampled on that same edge.
    - `valid`=1, state returns to IDLE, `busy`=0.
- `a`, `b` and `cin` never change during SHIFT; the update is atomic at completion.
- `start` while in SHIFT is ignored; `mode` is sampled only when a request is accepted.
- `mode`=11, and `mode`=10 without the count feature, are treated as broadcast.
- `rst_n` low at any time, including mid-shift:
  - All state and outputs clear immediately.
  - No `valid` is produced for the aborted request.

## Timing
- Broadcast: `start` sampled at edge k → outputs and `valid` change at edge k, visible for cycle k..k+1. Latency 1 cycle.
- Back-to-back broadcast: `start` held high produces `valid` every cycle with fresh pin values.
- Shift: `start` sampled at edge k.
  - Bits 0..N-1 are sampled at edges k+1..k+N.
  - Outputs and `valid` update at edge k+N; `busy` is high from edge k until edge k+N.
  - The next request is accepted at edge k+N+1 at the earliest.

## Configuration
- Macro: `PATTERN_BROADCASTER_COUNT_EN`.
- Defined: `mode`=10 is count mode. Each accepted request, in a single cycle like broadcast, drives:
  - `a` ← cnt.
  - `b` ← ~cnt.
  - `cin` ← cnt[0].
  - The pattern counter then increments, wrapping from 2^N−1 to 0.
- The pattern counter is N bits, reset to 0, and unaffected by the other modes.
- Not defined: no pattern counter is built; `mode`=10 behaves exactly as broadcast.

## Test plan
1. Reset check: assert `rst_n`=0 → `a`=0, `b`=0, `cin`=0, `valid`=0, `busy`=0. Release reset with `start`=0 → all outputs stay 0.
2. Broadcast, N=16:
   - pin_a=0, pin_b=1, pin_cin=0, one `start` → next cycle `a`=16'h0000, `b`=16'hFFFF, `cin`=0, `valid` high for 1 cycle.
   - Then pin_a=1, pin_b=0, pin_cin=1 → `a`=16'hFFFF, `b`=16'h0000, `cin`=1.
3. Shift, N=16:
   - Drive 16'hA5C3 on `pin_a` and 16'h3C5A on `pin_b`, LSB first, at edges k+1..k+16, with pin_cin=1 at edge k+16.
   - Required: at edge k+16, `a`=16'hA5C3, `b`=16'h3C5A, `cin`=1, `valid` 1 cycle.
   - `busy` high for 16 cycles; `a`/`b` unchanged during the shift.
4. Robustness:
   - Pulse `start` with `mode`=00 during a shift → ignored, with no early `valid`.
   - Assert `rst_n` after bit 8 → outputs 0 and no `valid`.
   - A subsequent full shift of 16'h1234 completes correctly.
5. Count mode, macro defined, N=4:
   - Three requests → `a`=0,1,2; `b`=F,E,D; `cin`=0,1,0.
   - Requests 17 and 18 → `a`=0, then 1 (wrap-around).
   - Macro undefined: `mode`=10 with pin_a=1 → `a`=4'hF.
